// File: rtl/dtc_sched_pkg.sv
// Shared types and the round-robin pick helper for shared-classifier schedulers.
package dtc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_IN_W  = 10;
  localparam int DEF_OUT_W = 77;

  // The helper works on the widest supported requester count.
  localparam int MAX_REQ  = 16;
  localparam int MAX_ID_W = 4;
  localparam int SUM_W    = MAX_ID_W + 1;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } pick_t;

  // First set bit of valid, searching upward from (ptr+1) mod n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                    input logic [MAX_ID_W-1:0] ptr,
                                    input int unsigned         n);
    pick_t           r;
    logic [SUM_W-1:0] s;
    r = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      s = {1'b0, ptr} + SUM_W'(k);
      if (s >= SUM_W'(n)) s = s - SUM_W'(n);
      if (k <= int'(n) && !r.found && valid[s[MAX_ID_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = s[MAX_ID_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dtc_share_sched_if.sv
// Requester and result-consumer handshake bundle of the shared classifier scheduler.
interface dtc_share_sched_if
  import dtc_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*IN_W-1:0] req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [OUT_W-1:0]      rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_hit;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_hit
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_hit
  );
endinterface

// File: rtl/dtc_rr_arbiter.sv
// Combinational round-robin pick: one-hot grant, binary index and any_valid.
module dtc_rr_arbiter
  import dtc_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any_valid
);

  pick_t p;

  // NOTE: every signal written here is assigned on every pass, so no latch is inferred.
  always_comb begin
    p         = rr_pick(MAX_REQ'(valid), MAX_ID_W'(ptr), N_REQ);
    any_valid = p.found;
    idx       = ID_W'(p.idx);
    grant     = p.found ? (N_REQ'(1) << p.idx) : '0;
  end

endmodule

// File: rtl/dtc_share_sched.sv
// Shares one combinational decision-tree classifier between N_REQ requesters,
// returning each captured class vector tagged with the requester id.
module dtc_share_sched
  import dtc_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int IN_W     = DEF_IN_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int EVAL_CYC = 1,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  dtc_share_sched_if.slave bus,
  output logic [IN_W-1:0]  dt_inp,
  input  logic [OUT_W-1:0] dt_outp,
  output logic             busy
);

  localparam int                 CNT_W    = (EVAL_CYC > 1) ? $clog2(EVAL_CYC) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(EVAL_CYC - 1);

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] g_onehot;
  logic [ID_W-1:0]  g_idx;
  logic             g_any;

  dtc_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .valid     (bus.req_valid),
    .ptr       (ptr),
    .grant     (g_onehot),
    .idx       (g_idx),
    .any_valid (g_any)
  );

  // Gated by rst_n so no requester sees an accept while the block is held in reset.
  assign bus.req_ready = (state == IDLE && rst_n) ? g_onehot : '0;
  assign busy          = (state != IDLE);

  // NOTE: non-blocking assignments make every register sample pre-edge values,
  // so the grant taken this edge is computed from the old ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= ID_W'(N_REQ - 1);
      cnt           <= '0;
      dt_inp        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_id    <= '0;
      bus.rsp_hit   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (g_any) begin
            dt_inp     <= bus.req_data[g_idx*IN_W +: IN_W];
            bus.rsp_id <= g_idx;
            ptr        <= g_idx;
            cnt        <= '0;
            state      <= EVAL;
          end
        end
        EVAL: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            bus.rsp_data  <= dt_outp;
            bus.rsp_hit   <= |dt_outp;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          // dt_inp and the response registers hold until the consumer accepts.
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtc_share_sched.sv
// Directed plus randomized bench for dtc_share_sched with an attached behavioural classifier.
module tb_dtc_share_sched;
  localparam int N   = 4;
  localparam int IW  = 10;
  localparam int OW  = 77;
  localparam int EC  = 1;
  localparam int IDW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] dt_inp;
  logic [OW-1:0] dt_outp;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_last = N - 1;
  int last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dtc_share_sched_if #(.N_REQ(N), .IN_W(IW), .OUT_W(OW), .ID_W(IDW)) bus ();

  dtc_share_sched #(
    .N_REQ(N), .IN_W(IW), .OUT_W(OW), .EVAL_CYC(EC), .ID_W(IDW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .dt_inp  (dt_inp),
    .dt_outp (dt_outp),
    .busy    (busy)
  );

  // Classifier: 0 -> only bit 11, 2 -> zero, anything else -> a data-dependent pattern.
  function automatic logic [OW-1:0] classify(input logic [IW-1:0] x);
    int b;
    if (x == 10'h002) return '0;
    b = (int'(x) * 7 + 11) % OW;
    return (OW'(1) << b) | (OW'(x) << 40);
  endfunction

  assign dt_outp = classify(dt_inp);

  // Round-robin reference: first valid requester after the last one granted.
  function automatic int pick(input logic [N-1:0] v, input int last);
    logic [N-1:0] t;
    for (int k = 1; k <= N; k++) begin
      t = v >> ((last + k) % N);
      if (t[0]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_zero(input string tag);
    check({tag, "_dt_inp"}, 128'(dt_inp), 128'(0));
    check({tag, "_rsp_valid"}, 128'(bus.rsp_valid), 128'(0));
    check({tag, "_rsp_data"}, 128'(bus.rsp_data), 128'(0));
    check({tag, "_rsp_id"}, 128'(bus.rsp_id), 128'(0));
    check({tag, "_rsp_hit"}, 128'(bus.rsp_hit), 128'(0));
    check({tag, "_req_ready"}, 128'(bus.req_ready), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  // One full transaction from IDLE: grant, evaluate, respond after 'stall' backpressure cycles.
  task automatic run_txn(input int stall, input bit drop, input logic [N-1:0] clr, output int g);
    logic [IW-1:0] ein;
    logic [OW-1:0] eout;
    logic [N-1:0]  eg;
    #1;
    g  = pick(bus.req_valid, model_last);
    eg = (g < 0) ? '0 : (N'(1) << g);
    check("grant", 128'(bus.req_ready), 128'(eg));
    check("busy_idle", 128'(busy), 128'(0));
    if (g < 0) return;
    ein  = bus.req_data[g*IW +: IW];
    eout = classify(ein);
    bus.rsp_ready = (stall == 0);
    tick();
    model_last = g;
    last_acc   = cyc;
    bus.req_valid = bus.req_valid & ~clr;
    if (drop) bus.req_valid[g] = 1'b0;
    check("eval_busy", 128'(busy), 128'(1));
    check("eval_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    check("eval_req_ready", 128'(bus.req_ready), 128'(0));
    check("eval_dt_inp", 128'(dt_inp), 128'(ein));
    tick();
    check("rsp_valid", 128'(bus.rsp_valid), 128'(1));
    check("rsp_data", 128'(bus.rsp_data), 128'(eout));
    check("rsp_id", 128'(bus.rsp_id), 128'(g));
    check("rsp_hit", 128'(bus.rsp_hit), 128'(|eout));
    for (int i = 0; i < stall; i++) begin
      tick();
      check("hold", 128'({bus.rsp_valid, bus.rsp_id, bus.rsp_data, dt_inp, bus.req_ready}),
            128'({1'b1, IDW'(g), eout, ein, N'(0)}));
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("resp_no_accept", 128'(bus.req_ready), 128'(0));
    tick();
    check("done_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    check("done_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    int g;
    int prev;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = N'($urandom);
      for (int r = 0; r < N; r++) bus.req_data[r*IW +: IW] = IW'($urandom);
      bus.rsp_ready = 1'($urandom);
      #1;
      idle_zero("in_reset");
      tick();
    end
    bus.req_valid = '0;
    rst_n = 1'b1;
    tick();
    idle_zero("after_reset");

    // Single request from requester 2 with an all-zero feature.
    bus.req_data[2*IW +: IW] = 10'h000;
    bus.req_valid = 4'b0100;
    run_txn(0, 1'b1, '0, g);
    check("single_id", 128'(g), 128'(2));

    // Dropout: 0,1,3 valid with ptr=2 -> 3 served, 0 withdrawn meanwhile -> 1 next.
    for (int r = 0; r < N; r++) bus.req_data[r*IW +: IW] = IW'($urandom);
    bus.req_data[1*IW +: IW] = 10'h002;
    bus.req_valid = 4'b1011;
    run_txn(1, 1'b1, 4'b0001, g);
    check("dropout_first", 128'(g), 128'(3));
    run_txn(0, 1'b1, '0, g);
    check("dropout_next", 128'(g), 128'(1));
    check("zero_rsp_data", 128'(bus.rsp_data), 128'(0));

    // Randomized traffic obeying the hold-until-ready rule.
    for (int t = 0; t < 24; t++) begin
      for (int r = 0; r < N; r++) begin
        if (!bus.req_valid[r] && $urandom_range(0, 1) == 1) begin
          bus.req_data[r*IW +: IW] = IW'($urandom);
          bus.req_valid[r] = 1'b1;
        end
      end
      if (bus.req_valid == '0) begin
        prev = $urandom_range(0, N - 1);
        bus.req_data[prev*IW +: IW] = IW'($urandom);
        bus.req_valid[prev] = 1'b1;
      end
      run_txn($urandom_range(0, 3), 1'b1, '0, g);
    end

    // Long backpressure with every requester waiting.
    for (int r = 0; r < N; r++) bus.req_data[r*IW +: IW] = IW'($urandom);
    bus.req_valid = '1;
    run_txn(10, 1'b0, '0, g);

    // Reset while a response is pending.
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    check("pre_reset_rsp_valid", 128'(bus.rsp_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    idle_zero("mid_reset");
    bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
    model_last = N - 1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_ghost_rsp", 128'({bus.rsp_valid, busy}), 128'(0));
    end

    // Fairness from the reset pointer: 0,1,2,3,0,1 one accept every 3 cycles.
    for (int r = 0; r < N; r++) bus.req_data[r*IW +: IW] = IW'($urandom);
    bus.req_valid = '1;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      run_txn(0, 1'b0, '0, g);
      check("fair_order", 128'(g), 128'(k % N));
      if (k > 0) check("fair_spacing", 128'(last_acc - prev), 128'(EC + 2));
      prev = last_acc;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
